// File: rtl/vga_cfg_pkg.sv
// Shared constants for the VGA configuration path: background codes,
// default raster size and the switch-to-background priority encoder.
package vga_cfg_pkg;

    localparam int BG_W = 3;

    localparam logic [BG_W-1:0] BG_BLACK = 3'd0;
    localparam logic [BG_W-1:0] BG_WHITE = 3'd1;
    localparam logic [BG_W-1:0] BG_BLUE  = 3'd2;
    localparam logic [BG_W-1:0] BG_RED   = 3'd3;
    localparam logic [BG_W-1:0] BG_GREEN = 3'd4;
    localparam logic [BG_W-1:0] BG_NONE  = 3'd7;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    // sw = {green, red, blue, white, black}; black wins, green loses.
    function automatic logic [BG_W-1:0] bg_encode(input logic [4:0] sw);
        logic [BG_W-1:0] code;
        if (sw[0]) begin
            code = BG_BLACK;
        end else if (sw[1]) begin
            code = BG_WHITE;
        end else if (sw[2]) begin
            code = BG_BLUE;
        end else if (sw[3]) begin
            code = BG_RED;
        end else if (sw[4]) begin
            code = BG_GREEN;
        end else begin
            code = BG_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Two-flop synchroniser for a bundle of asynchronous inputs, with a
// falling-edge pulse derived from bit 0 of the bundle.
module vga_sync_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         fall
);

    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;
    logic         prev_r;

    // Metastability chain plus one-cycle history of bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= '0;
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            prev_r <= sync_r[0];
        end
    end

    assign dout = sync_r;
    assign fall = prev_r & ~sync_r[0];

endmodule

// File: rtl/vga_frame_scheduler.sv
// Commits background selection and sprite position only at the start of
// vertical sync so the pixel pipeline never sees a mid-frame change.
module vga_frame_scheduler
    import vga_cfg_pkg::*;
#(
    parameter int H_ACTIVE        = H_ACTIVE_DEF,
    parameter int V_ACTIVE        = V_ACTIVE_DEF,
    parameter int SPRITE_SIZE     = 64,
    parameter int STEP            = 4,
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic            iVGA_CLK,
    input  logic            iRST_n,
    input  logic            iVS,
    input  logic            sw_black,
    input  logic            sw_white,
    input  logic            sw_blue,
    input  logic            sw_red,
    input  logic            sw_green,
    input  logic            btn_up,
    input  logic            btn_down,
    input  logic            btn_left,
    input  logic            btn_right,
    output logic [BG_W-1:0] oBG_SEL,
    output logic            oBG_CHANGED,
    output logic [9:0]      oSPRITE_X,
    output logic [9:0]      oSPRITE_Y,
    output logic            oFRAME_TICK,
    output logic            oBUSY
);

    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;

    localparam logic signed [10:0] X_MAX_S = 11'(H_ACTIVE - SPRITE_SIZE);
    localparam logic signed [10:0] Y_MAX_S = 11'(V_ACTIVE - SPRITE_SIZE);
    localparam logic signed [10:0] STEP_S  = 11'(STEP);
    localparam logic [9:0]         X_RST   = 10'((H_ACTIVE - SPRITE_SIZE) / 2);
    localparam logic [9:0]         Y_RST   = 10'((V_ACTIVE - SPRITE_SIZE) / 2);

    logic [9:0]       in_sync_s;
    logic             tick_s;
    logic [BG_W-1:0]  req_s;
    logic             up_s, down_s, left_s, right_s;

    logic [0:0]       state_r, state_n;
    logic [BG_W-1:0]  cand_r, cand_n;
    logic [CNT_W-1:0] cnt_r, cnt_n, cnt_inc_s;
    logic [BG_W-1:0]  bg_sel_r, bg_sel_n;
    logic             commit_s;
    logic             bg_changed_r, frame_tick_r, busy_r;
    logic [9:0]       x_r, x_n, y_r, y_n;
    logic signed [10:0] dx_s, dy_s;

    // Bit 0 is VS so its falling edge becomes the frame tick.
    vga_sync_edge #(.W(10)) u_sync (
        .clk   (iVGA_CLK),
        .rst_n (iRST_n),
        .din   ({btn_right, btn_left, btn_down, btn_up,
                 sw_green, sw_red, sw_blue, sw_white, sw_black, iVS}),
        .dout  (in_sync_s),
        .fall  (tick_s)
    );

    assign req_s   = bg_encode(in_sync_s[5:1]);
    assign up_s    = in_sync_s[6];
    assign down_s  = in_sync_s[7];
    assign left_s  = in_sync_s[8];
    assign right_s = in_sync_s[9];

    assign cnt_inc_s = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);

    function automatic logic [9:0] clamp_pos(input logic [9:0] pos,
                                             input logic signed [10:0] d,
                                             input logic signed [10:0] hi);
        logic signed [10:0] sum;
        logic [9:0]         res;
        sum = $signed({1'b0, pos}) + d;
        if (sum < 11'sd0) begin
            res = 10'd0;
        end else if (sum > hi) begin
            res = hi[9:0];
        end else begin
            res = sum[9:0];
        end
        return res;
    endfunction

    // Background debounce FSM; only a frame tick can move it.
    always_comb begin
        state_n  = state_r;
        cand_n   = cand_r;
        cnt_n    = cnt_r;
        bg_sel_n = bg_sel_r;
        commit_s = 1'b0;
        if (tick_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s == BG_NONE || req_s == bg_sel_r) begin
                        state_n = ST_IDLE;
                    end else if (DEBOUNCE_FRAMES <= 1) begin
                        bg_sel_n = req_s;
                        commit_s = 1'b1;
                        cnt_n    = '0;
                    end else begin
                        cand_n  = req_s;
                        cnt_n   = CNT_W'(1);
                        state_n = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (req_s == BG_NONE || req_s == bg_sel_r) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else if (req_s != cand_r) begin
                        cand_n = req_s;
                        cnt_n  = CNT_W'(1);
                    end else if ((32'(cnt_r) + 32'd1) >= $unsigned(DEBOUNCE_FRAMES)) begin
                        bg_sel_n = cand_r;
                        commit_s = 1'b1;
                        state_n  = ST_IDLE;
                        cnt_n    = '0;
                    end else begin
                        cnt_n = cnt_inc_s;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // Sprite step per tick; opposing buttons cancel, edges clamp.
    always_comb begin
        dx_s = 11'sd0;
        dy_s = 11'sd0;
        x_n  = x_r;
        y_n  = y_r;
        if (right_s && !left_s) begin
            dx_s = STEP_S;
        end else if (left_s && !right_s) begin
            dx_s = -STEP_S;
        end else begin
            dx_s = 11'sd0;
        end
        if (down_s && !up_s) begin
            dy_s = STEP_S;
        end else if (up_s && !down_s) begin
            dy_s = -STEP_S;
        end else begin
            dy_s = 11'sd0;
        end
        if (tick_s) begin
            x_n = clamp_pos(x_r, dx_s, X_MAX_S);
            y_n = clamp_pos(y_r, dy_s, Y_MAX_S);
        end else begin
            x_n = x_r;
            y_n = y_r;
        end
    end

    // State and output registers.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_r      <= ST_IDLE;
            cand_r       <= BG_NONE;
            cnt_r        <= '0;
            bg_sel_r     <= BG_WHITE;
            bg_changed_r <= 1'b0;
            frame_tick_r <= 1'b0;
            busy_r       <= 1'b0;
            x_r          <= X_RST;
            y_r          <= Y_RST;
        end else begin
            state_r      <= state_n;
            cand_r       <= cand_n;
            cnt_r        <= cnt_n;
            bg_sel_r     <= bg_sel_n;
            bg_changed_r <= commit_s;
            frame_tick_r <= tick_s;
            busy_r       <= (state_n == ST_ARMED);
            x_r          <= x_n;
            y_r          <= y_n;
        end
    end

    assign oBG_SEL     = bg_sel_r;
    assign oBG_CHANGED = bg_changed_r;
    assign oFRAME_TICK = frame_tick_r;
    assign oBUSY       = busy_r;
    assign oSPRITE_X   = x_r;
    assign oSPRITE_Y   = y_r;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Directed bench: each VS falling edge queues the expected per-frame state,
// which is popped and checked when the DUT raises its frame tick.
module tb_vga_frame_scheduler;

    typedef struct {
        int bg;
        int chg;
        int busy;
        int x;
        int y;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vs = 1'b1;
    logic [4:0] sw = 5'd0;
    logic [3:0] btn = 4'd0;
    logic [2:0] bg_sel;
    logic       bg_changed, frame_tick, busy;
    logic [9:0] spr_x, spr_y;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    vga_frame_scheduler dut (
        .iVGA_CLK    (clk),
        .iRST_n      (rst_n),
        .iVS         (vs),
        .sw_black    (sw[0]),
        .sw_white    (sw[1]),
        .sw_blue     (sw[2]),
        .sw_red      (sw[3]),
        .sw_green    (sw[4]),
        .btn_up      (btn[0]),
        .btn_down    (btn[1]),
        .btn_left    (btn[2]),
        .btn_right   (btn[3]),
        .oBG_SEL     (bg_sel),
        .oBG_CHANGED (bg_changed),
        .oSPRITE_X   (spr_x),
        .oSPRITE_Y   (spr_y),
        .oFRAME_TICK (frame_tick),
        .oBUSY       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic exp_t mk(input int bg, input int chg, input int busy_e, input int x, input int y);
        exp_t e;
        e.bg = bg; e.chg = chg; e.busy = busy_e; e.x = x; e.y = y;
        return e;
    endfunction

    task automatic set_in(input logic [4:0] s, input logic [3:0] b);
        sw  = s;
        btn = b;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_bg"}, 32'(bg_sel), 32'd1);
        chk({tag, "_chg"}, 32'(bg_changed), 32'd0);
        chk({tag, "_tick"}, 32'(frame_tick), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_x"}, 32'(spr_x), 32'd288);
        chk({tag, "_y"}, 32'(spr_y), 32'd208);
    endtask

    // One VS period: falling edge must tick once, rising edge never.
    task automatic frame(input string tag, input exp_t e);
        exp_t got_e;
        bit   got;
        int   spurious;
        sb.push_back(e);
        vs  = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (frame_tick) begin
                got   = 1'b1;
                got_e = sb.pop_front();
                chk({tag, "_bg"}, 32'(bg_sel), 32'(got_e.bg));
                chk({tag, "_chg"}, 32'(bg_changed), 32'(got_e.chg));
                chk({tag, "_busy"}, 32'(busy), 32'(got_e.busy));
                chk({tag, "_x"}, 32'(spr_x), 32'(got_e.x));
                chk({tag, "_y"}, 32'(spr_y), 32'(got_e.y));
            end
        end
        if (!got) begin
            chk({tag, "_tick_timeout"}, 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        @(negedge clk);
        chk({tag, "_tick_pulse"}, 32'(frame_tick), 32'd0);
        chk({tag, "_chg_pulse"}, 32'(bg_changed), 32'd0);
        repeat (3) @(negedge clk);
        vs = 1'b1;
        spurious = 0;
        repeat (8) begin
            @(negedge clk);
            if (frame_tick) spurious++;
        end
        chk({tag, "_rise_notick"}, 32'(spurious), 32'd0);
    endtask

    initial begin
        // Reset, all quiet
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_vals("post_rst");
        frame("idle1", mk(1, 0, 0, 288, 208));
        frame("idle2", mk(1, 0, 0, 288, 208));

        // Blue for one tick only: aborts, no commit
        set_in(5'b00100, 4'd0);
        frame("blue_t1", mk(1, 0, 1, 288, 208));
        set_in(5'b00000, 4'd0);
        frame("blue_abort", mk(1, 0, 0, 288, 208));

        // Black held two ticks: commit on the second
        set_in(5'b00001, 4'd0);
        frame("black_t1", mk(1, 0, 1, 288, 208));
        frame("black_t2", mk(0, 1, 0, 288, 208));
        set_in(5'b00000, 4'd0);
        frame("black_rel", mk(0, 0, 0, 288, 208));

        // Blue beats red; then red and green each restart the candidate
        set_in(5'b01100, 4'd0);
        frame("bluered_t1", mk(0, 0, 1, 288, 208));
        frame("bluered_t2", mk(2, 1, 0, 288, 208));
        set_in(5'b01000, 4'd0);
        frame("red_t1", mk(2, 0, 1, 288, 208));
        set_in(5'b10000, 4'd0);
        frame("green_restart", mk(2, 0, 1, 288, 208));
        set_in(5'b00000, 4'd0);
        frame("green_rel", mk(2, 0, 0, 288, 208));

        // Right+down to the far clamps
        set_in(5'b00000, 4'b1010);
        for (int k = 1; k <= 75; k++) begin
            frame("rd_run", mk(2, 0, 0, (288 + 4*k > 576) ? 576 : 288 + 4*k,
                                         (208 + 4*k > 416) ? 416 : 208 + 4*k));
        end
        // Left+up to zero, must not wrap
        set_in(5'b00000, 4'b0101);
        for (int k = 1; k <= 150; k++) begin
            frame("lu_run", mk(2, 0, 0, (576 - 4*k < 0) ? 0 : 576 - 4*k,
                                         (416 - 4*k < 0) ? 0 : 416 - 4*k));
        end
        set_in(5'b00000, 4'b1000);
        for (int k = 1; k <= 5; k++) frame("r_step", mk(2, 0, 0, 4*k, 0));
        set_in(5'b00000, 4'b0010);
        for (int k = 1; k <= 3; k++) frame("d_step", mk(2, 0, 0, 20, 4*k));
        // Opposing pairs cancel
        set_in(5'b00000, 4'b1111);
        frame("cancel_all1", mk(2, 0, 0, 20, 12));
        frame("cancel_all2", mk(2, 0, 0, 20, 12));
        set_in(5'b00000, 4'b1100);
        frame("cancel_lr", mk(2, 0, 0, 20, 12));

        // Reset while ARMED: immediate, then debounce starts afresh
        set_in(5'b01000, 4'd0);
        frame("red_armed", mk(2, 0, 1, 20, 12));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        frame("red_after_rst1", mk(1, 0, 1, 288, 208));
        frame("red_after_rst2", mk(3, 1, 0, 288, 208));

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
